// File: rtl/debounce_pkg.sv
// Shared types for the debouncer: FSM state encoding and reset state.
package debounce_pkg;

    // Two stable states (ZERO, ONE) and two qualifying states (WAIT1, WAIT0).
    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

    localparam db_state_t DB_RESET_STATE = ZERO;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops clear on synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/debounce_fsm.sv
// Switch debouncer: four-state Moore FSM with a down-counting stability timer.
// A level change is accepted only after the new value has been sampled for
// 2^CNT_W + 1 consecutive cycles; any bounce back restarts qualification.
// Build option: define DEBOUNCE_SYNC_EN to put a 2-flop synchronizer in front
// of the FSM (adds 2 cycles of latency) for asynchronous board inputs.
module debounce_fsm
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_W = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic             sw_s;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw),
        .q     (sw_s)
    );
`else
    assign sw_s = sw;
`endif

    // State and stability counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DB_RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter update; the counter is reloaded on every
    // qualifying edge, so it is never decremented past zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ZERO: begin
                if (sw_s) begin
                    state_d = WAIT1;
                    cnt_d   = CntMax;
                end
            end
            WAIT1: begin
                if (!sw_s) begin
                    state_d = ZERO;
                end else if (cnt_q == '0) begin
                    state_d = ONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ONE: begin
                if (!sw_s) begin
                    state_d = WAIT0;
                    cnt_d   = CntMax;
                end
            end
            WAIT0: begin
                if (sw_s) begin
                    state_d = ONE;
                end else if (cnt_q == '0) begin
                    state_d = ZERO;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ZERO;
            end
        endcase
    end

    // Output decoded from the state register only, never from sw.
    assign db_level = (state_q == ONE) || (state_q == WAIT0);

endmodule

// File: tb/tb_debounce_fsm.sv
// Self-checking bench for debounce_fsm (CNT_W = 3). A behavioural model tracks
// how many consecutive samples have disagreed with the current clean level and
// flips the level once that run reaches 2^CNT_W + 1 samples.
module tb_debounce_fsm;

    localparam int unsigned CNT_W = 3;
    localparam int WIN = (1 << CNT_W) + 1;
`ifdef DEBOUNCE_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif
    localparam int LAT = WIN + SYNC_DLY;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sw = 1'b0;
    logic db_level;

    int checks = 0;
    int errors = 0;

    // Model state
    logic m_lvl;
    logic m_s1;
    logic m_s2;
    logic m_samp;
    int   m_run = 0;
    int   m_rises = 0;

    // Compare-process state
    bit   chk_en = 1'b0;
    logic dut_prev = 1'b0;
    int   dut_rises = 0;

    debounce_fsm #(
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .db_level (db_level)
    );

    always #5 clk = ~clk;

    // Behavioural reference: consecutive-disagreement run length.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_lvl = 1'b0;
                m_run = 0;
                m_s1  = 1'b0;
                m_s2  = 1'b0;
            end else begin
                m_samp = (SYNC_DLY != 0) ? m_s2 : sw;
                m_s2   = m_s1;
                m_s1   = sw;
                if (m_samp != m_lvl) begin
                    m_run = m_run + 1;
                    if (m_run == WIN) begin
                        m_lvl = m_samp;
                        m_run = 0;
                        if (m_samp) m_rises = m_rises + 1;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end
    end

    // Per-cycle comparison on the falling edge, plus downstream tick counting.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                checks = checks + 1;
                if (db_level !== m_lvl) begin
                    errors = errors + 1;
                    $display("FAIL cycle_cmp t=%0t db_level=%b expected=%b",
                             $time, db_level, m_lvl);
                end
                if (db_level === 1'b1 && dut_prev === 1'b0) dut_rises = dut_rises + 1;
                dut_prev = db_level;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        sw    = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        check("reset_level", 32'(db_level), 32'd0);

        // Clean rise then release.
        sw = 1'b1;
        repeat (LAT - 1) step();
        check("rise_early", 32'(db_level), 32'd0);
        step();
        check("rise_at_latency", 32'(db_level), 32'd1);
        repeat (5) step();
        check("rise_hold", 32'(db_level), 32'd1);
        sw = 1'b0;
        repeat (LAT - 1) step();
        check("fall_early", 32'(db_level), 32'd1);
        step();
        check("fall_at_latency", 32'(db_level), 32'd0);

        // Bounce rejection: 1,0,1,0 every 3 cycles, then hold high.
        for (int p = 0; p < 4; p++) begin
            sw = (p % 2 == 0);
            repeat (3) step();
            check("bounce_hold_low", 32'(db_level), 32'd0);
        end
        sw = 1'b1;
        repeat (LAT - 1) step();
        check("bounce_early", 32'(db_level), 32'd0);
        step();
        check("bounce_rise", 32'(db_level), 32'd1);

        // Glitch low while high must not drop the level.
        sw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("glitch_low", 32'(db_level), 32'd1);
        end
        sw = 1'b1;
        repeat (LAT + 2) step();
        check("glitch_recover", 32'(db_level), 32'd1);

        // Reset in the middle of a rising qualification.
        sw = 1'b0;
        repeat (LAT + 1) step();
        check("pre_reset_low", 32'(db_level), 32'd0);
        sw = 1'b1;
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (LAT - 1) step();
        check("reset_mid_early", 32'(db_level), 32'd0);
        step();
        check("reset_mid_rise", 32'(db_level), 32'd1);

        // Randomized bursts with occasional resets.
        for (int n = 0; n < 600; n++) begin
            sw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            repeat ($urandom_range(1, 14)) step();
        end
        step();

        // Downstream edge detector sees one tick per debounced rise.
        check("tick_count", 32'(dut_rises), 32'(m_rises));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
